anc_i2s_bridge: RTL

Audio-side counterpart of the ANC core's sample interface. Receives an I2S stream carrying the reference mic (left, x) and error mic (right, e), buffers complete {x,e} pairs in a small FIFO, and presents them to the ANC core through its in_valid/controller_ready handshake together with the static desired-output and step-size words. It captures the core's out_sample/out_valid result and serializes it back onto the I2S data-out line for the DAC.

---
 rtl/anc_pkg.sv | 18 +
 rtl/anc_sync_fifo.sv | 51 +++++
 rtl/anc_i2s_bridge.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/anc_pkg.sv
`default_nettype none
// ============================================================================
// anc_pkg: shared sample types for the ANC audio-side bridge. Revision: 1.0
// ============================================================================
package anc_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PAIR_W   = 2 * SAMPLE_W;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t x;
    sample_t e;
  } sample_pair_t;

endpackage
`default_nettype wire

// File: rtl/anc_sync_fifo.sv
`default_nettype none
// ============================================================================
// anc_sync_fifo: single-clock FIFO, power-of-two depth. Revision: 1.0
// ============================================================================
module anc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/anc_i2s_bridge.sv
`default_nettype none
// ============================================================================
// anc_i2s_bridge: I2S rx/tx to ANC core sample handshake bridge. Revision: 1.0
// ============================================================================
module anc_i2s_bridge
  import anc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bclk,
  input  logic                          lrclk,
  input  logic                          sdin,
  output logic                          sdout,
  input  logic signed [SAMPLE_W-1:0]    a_cfg,
  input  logic signed [SAMPLE_W-1:0]    u_cfg,
  output logic                          anc_in_valid,
  input  logic                          anc_ready,
  output logic signed [SAMPLE_W-1:0]    anc_x,
  output logic signed [SAMPLE_W-1:0]    anc_e,
  output logic signed [SAMPLE_W-1:0]    anc_a,
  output logic signed [SAMPLE_W-1:0]    anc_u,
  input  logic signed [SAMPLE_W-1:0]    anc_out_sample,
  input  logic                          anc_out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf,
  output logic                          urun,
  input  logic                          flag_clr
);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_DELAY = 2'd1;
  localparam logic [1:0] RX_SHIFT = 2'd2;
  localparam logic [1:0] RX_DONE  = 2'd3;
  localparam logic [4:0] TX_BITS  = 5'(SAMPLE_W);

  logic [SYNC_STAGES-1:0] bclk_sync_q, lr_sync_q, sd_sync_q;
  logic bclk_prev_q, lr_prev_q;
  logic bclk_s, lr_s, sd_s, bclk_rise, bclk_fall, lr_edge, lr_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
    end else begin
      bclk_sync_q[0] <= bclk;
      lr_sync_q[0]   <= lrclk;
      sd_sync_q[0]   <= sdin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_sync_q[i] <= bclk_sync_q[i-1];
        lr_sync_q[i]   <= lr_sync_q[i-1];
        sd_sync_q[i]   <= sd_sync_q[i-1];
      end
      bclk_prev_q <= bclk_s;
      lr_prev_q   <= lr_s;
    end
  end

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lr_s      = lr_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign bclk_fall = ~bclk_s & bclk_prev_q;
  assign lr_edge   = lr_s ^ lr_prev_q;
  assign lr_fall   = lr_edge & ~lr_s;

  logic [1:0]          rx_state_q, rx_state_d;
  logic [3:0]          rx_cnt_q, rx_cnt_d;
  logic [SAMPLE_W-2:0] rx_shift_q, rx_shift_d;
  logic                rx_chan_q, rx_chan_d;
  logic                pend_q, pend_d;
  sample_t             x_q, x_d;
  logic                push_q, push_d;
  sample_pair_t        pair_q, pair_d;
  logic [SAMPLE_W-1:0] rx_word;

  assign rx_word = {rx_shift_q, sd_s};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_chan_d  = rx_chan_q;
    pend_d     = pend_q;
    x_d        = x_q;
    push_d     = 1'b0;
    pair_d     = pair_q;
    if (lr_edge) begin
      rx_state_d = RX_DELAY;
      rx_cnt_d   = '0;
      rx_chan_d  = lr_s;
      // A new left word invalidates any x left over from a broken frame.
      if (!lr_s) pend_d = 1'b0;
    end else if (bclk_rise) begin
      case (rx_state_q)
        RX_DELAY: rx_state_d = RX_SHIFT;
        RX_SHIFT: begin
          rx_shift_d = rx_word[SAMPLE_W-2:0];
          rx_cnt_d   = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'(SAMPLE_W-1)) begin
            rx_state_d = RX_DONE;
            if (!rx_chan_q) begin
              x_d    = rx_word;
              pend_d = 1'b1;
            end else if (pend_q) begin
              push_d   = 1'b1;
              pair_d.x = x_q;
              pair_d.e = rx_word;
              pend_d   = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_chan_q  <= 1'b0;
      pend_q     <= 1'b0;
      x_q        <= '0;
      push_q     <= 1'b0;
      pair_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_chan_q  <= rx_chan_d;
      pend_q     <= pend_d;
      x_q        <= x_d;
      push_q     <= push_d;
      pair_q     <= pair_d;
    end
  end

  sample_pair_t fifo_rdata;
  logic         fifo_full, fifo_empty, pop;

  anc_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (pop),
    .wdata (pair_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  logic    in_valid_q, ovf_q, urun_q, fresh_q, sdout_q;
  sample_t anc_x_q, anc_e_q, anc_a_q, anc_u_q, hold_q, tx_word_q;
  logic [SAMPLE_W-1:0] tx_shift_q;
  logic [4:0]          tx_cnt_q;

  assign pop = !fifo_empty && anc_ready && !in_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      anc_x_q    <= '0;
      anc_e_q    <= '0;
      anc_a_q    <= '0;
      anc_u_q    <= '0;
      ovf_q      <= 1'b0;
      urun_q     <= 1'b0;
      fresh_q    <= 1'b0;
      hold_q     <= '0;
      tx_word_q  <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= TX_BITS;
      sdout_q    <= 1'b0;
    end else begin
      in_valid_q <= pop;
      if (pop) begin
        anc_x_q <= fifo_rdata.x;
        anc_e_q <= fifo_rdata.e;
      end
      anc_a_q <= a_cfg;
      anc_u_q <= u_cfg;
      ovf_q   <= (push_q && fifo_full && !pop) || (ovf_q && !flag_clr);
      urun_q  <= (lr_fall && !fresh_q) || (urun_q && !flag_clr);
      if (anc_out_valid) hold_q <= anc_out_sample;
      if (anc_out_valid)  fresh_q <= 1'b1;
      else if (lr_fall)   fresh_q <= 1'b0;
      if (lr_fall) tx_word_q <= hold_q;
      // The bclk fall coincident with a word-select change is the I2S delay slot.
      if (lr_edge) begin
        tx_shift_q <= lr_fall ? hold_q : tx_word_q;
        tx_cnt_q   <= '0;
        sdout_q    <= 1'b0;
      end else if (bclk_fall) begin
        if (tx_cnt_q != TX_BITS) begin
          sdout_q    <= tx_shift_q[SAMPLE_W-1];
          tx_shift_q <= {tx_shift_q[SAMPLE_W-2:0], 1'b0};
          tx_cnt_q   <= tx_cnt_q + 5'd1;
        end else begin
          sdout_q <= 1'b0;
        end
      end
    end
  end

  assign anc_in_valid = in_valid_q;
  assign anc_x        = anc_x_q;
  assign anc_e        = anc_e_q;
  assign anc_a        = anc_a_q;
  assign anc_u        = anc_u_q;
  assign ovf          = ovf_q;
  assign urun         = urun_q;
  assign sdout        = sdout_q;

endmodule
`default_nettype wire
